// File: rtl/decode_issue_if.sv
// Decode/issue bus: IF/ID side, write-back port and ID/EX outputs.
// slave = the decode/issue stage, master = whoever drives fetch, execute and write-back.
interface decode_issue_if #(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 16,
  parameter int REG_W   = 3
);
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic               uses_rs;
  logic               uses_rt;
  logic               dst_en;
  logic [REG_W-1:0]   dst_reg;
  logic               dst_load;
  logic               id_ready;
  logic               ex_ready;
  logic               flush;
  logic               wb_en;
  logic [REG_W-1:0]   wb_reg;
  logic [DATA_W-1:0]  wb_data;
  logic               ex_valid;
  logic [INSTR_W-1:0] ex_instr;
  logic [DATA_W-1:0]  ex_r1;
  logic [DATA_W-1:0]  ex_r2;
  logic               ex_dst_en;
  logic [REG_W-1:0]   ex_dst_reg;
  logic               ex_load;
  logic               err;

  modport slave (
    input  if_valid, if_instr, uses_rs, uses_rt, dst_en, dst_reg, dst_load,
    input  ex_ready, flush, wb_en, wb_reg, wb_data,
    output id_ready, ex_valid, ex_instr, ex_r1, ex_r2, ex_dst_en, ex_dst_reg, ex_load, err
  );

  modport master (
    output if_valid, if_instr, uses_rs, uses_rt, dst_en, dst_reg, dst_load,
    output ex_ready, flush, wb_en, wb_reg, wb_data,
    input  id_ready, ex_valid, ex_instr, ex_r1, ex_r2, ex_dst_en, ex_dst_reg, ex_load, err
  );
endinterface

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file with write-back bypass, load-use interlock
// and a registered ID/EX slot with valid/ready handshake and flush.
module decode_issue_stage #(
  parameter int DATA_W   = 16,
  parameter int INSTR_W  = 16,
  parameter int NREGS    = 8,
  parameter int REG_W    = 3,
  parameter int RS_LSB   = 8,
  parameter int RT_LSB   = 5,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  decode_issue_if.slave    bus
);

  logic [DATA_W-1:0] rf [NREGS];
  logic [REG_W-1:0]  rs, rt;
  logic [DATA_W-1:0] rd1, rd2;
  logic              wb_wr, wb_bad;
  logic              stall, advance, id_ready;

  function automatic logic in_range(input logic [REG_W-1:0] s);
    return int'(s) < NREGS;
  endfunction

  // readable/writable: implemented and not the hard-wired zero register
  function automatic logic live_sel(input logic [REG_W-1:0] s);
    return in_range(s) && !(ZERO_REG != 0 && s == '0);
  endfunction

  assign rs     = bus.if_instr[RS_LSB +: REG_W];
  assign rt     = bus.if_instr[RT_LSB +: REG_W];
  assign wb_wr  = bus.wb_en && live_sel(bus.wb_reg);
  assign wb_bad = bus.wb_en && !in_range(bus.wb_reg);

  // Same-cycle write-back wins over the stored value.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (live_sel(rs)) rd1 = (bus.wb_en && bus.wb_reg == rs) ? bus.wb_data : rf[rs];
    if (live_sel(rt)) rd2 = (bus.wb_en && bus.wb_reg == rt) ? bus.wb_data : rf[rt];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_wr) begin
      rf[bus.wb_reg] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.err <= 1'b0;
    else      bus.err <= wb_bad;
  end

  assign stall = bus.if_valid && bus.ex_valid && bus.ex_load && bus.ex_dst_en &&
                 ((bus.uses_rs && rs == bus.ex_dst_reg) ||
                  (bus.uses_rt && rt == bus.ex_dst_reg));
  assign advance  = bus.ex_ready || !bus.ex_valid;
  assign id_ready = rst && advance && !stall && !bus.flush;
  assign bus.id_ready = id_ready;

  // Held entries keep their issue-time operands; later write-backs are forwarded downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ex_valid   <= 1'b0;
      bus.ex_instr   <= '0;
      bus.ex_r1      <= '0;
      bus.ex_r2      <= '0;
      bus.ex_dst_en  <= 1'b0;
      bus.ex_dst_reg <= '0;
      bus.ex_load    <= 1'b0;
    end else if (bus.flush) begin
      bus.ex_valid <= 1'b0;
    end else if (advance) begin
      bus.ex_valid <= bus.if_valid && !stall;
      if (bus.if_valid && id_ready) begin
        bus.ex_instr   <= bus.if_instr;
        bus.ex_r1      <= rd1;
        bus.ex_r2      <= rd2;
        bus.ex_dst_en  <= bus.dst_en;
        bus.ex_dst_reg <= bus.dst_reg;
        bus.ex_load    <= bus.dst_load;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: randomized traffic plus directed
// bypass/load-use/backpressure/flush/reset cases, and a ZERO_REG/NREGS=6 instance.
module tb_decode_issue_stage;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] r1;
    logic [15:0] r2;
    logic        de;
    logic [2:0]  dr;
    logic        ld;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_issue_if #(.DATA_W(16), .INSTR_W(16), .REG_W(3)) bus ();
  decode_issue_if #(.DATA_W(16), .INSTR_W(16), .REG_W(3)) bus_z ();

  decode_issue_stage #(.NREGS(8), .ZERO_REG(0)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  decode_issue_stage #(.NREGS(6), .ZERO_REG(1)) u_dut_z (
    .clk(clk), .rst(rst), .bus(bus_z)
  );

  int n_chk  = 0;
  int n_fail = 0;

  exp_t        sb[$];
  logic [15:0] mrf [8];
  logic        m_valid, m_load, m_de;
  logic [2:0]  m_dst;
  logic        last_acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] rs, input logic [2:0] rt,
                                     input logic [4:0] tag);
    return {tag, rs, rt, tag};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) mrf[i] = 16'h0;
    m_valid = 1'b0; m_load = 1'b0; m_de = 1'b0; m_dst = 3'd0;
    sb.delete();
  endfunction

  task automatic idle_inputs();
    bus.if_valid = 0; bus.if_instr = 0; bus.uses_rs = 0; bus.uses_rt = 0;
    bus.dst_en = 0; bus.dst_reg = 0; bus.dst_load = 0; bus.ex_ready = 1;
    bus.flush = 0; bus.wb_en = 0; bus.wb_reg = 0; bus.wb_data = 0;
  endtask

  // One cycle on the main instance: drive at negedge, predict from the spec rules.
  task automatic step(input logic iv, input logic [15:0] ins, input logic urs, input logic urt,
                      input logic de, input logic [2:0] dr, input logic dl,
                      input logic er, input logic fl,
                      input logic we, input logic [2:0] wr, input logic [15:0] wd);
    logic [2:0]  rs, rt;
    logic        st, adv, idr, acc;
    logic [15:0] nrf [8];
    exp_t        e;
    @(negedge clk);
    bus.if_valid = iv; bus.if_instr = ins; bus.uses_rs = urs; bus.uses_rt = urt;
    bus.dst_en = de; bus.dst_reg = dr; bus.dst_load = dl;
    bus.ex_ready = er; bus.flush = fl;
    bus.wb_en = we; bus.wb_reg = wr; bus.wb_data = wd;
    #1;
    rs  = ins[10:8];
    rt  = ins[7:5];
    st  = iv && m_valid && m_load && m_de && ((urs && rs == m_dst) || (urt && rt == m_dst));
    adv = er || !m_valid;
    idr = adv && !st && !fl;
    chk("id_ready", {31'b0, bus.id_ready}, {31'b0, idr});
    chk("ex_valid", {31'b0, bus.ex_valid}, {31'b0, m_valid});
    chk("err_main", {31'b0, bus.err}, 32'h0);
    // operands seen by an issue = register contents after this cycle's write-back
    nrf = mrf;
    if (we) nrf[wr] = wd;
    acc = iv && idr;
    if (acc) begin
      e.instr = ins; e.r1 = nrf[rs]; e.r2 = nrf[rt];
      e.de = de; e.dr = dr; e.ld = dl;
      sb.push_back(e);
    end
    if (fl) m_valid = 1'b0;
    else if (adv) begin
      m_valid = acc;
      if (acc) begin m_load = dl; m_de = de; m_dst = dr; end
    end
    mrf = nrf;
    last_acc = acc;
  endtask

  task automatic idle_step();
    step(0, 16'h0, 0, 0, 0, 3'd0, 0, 1, 0, 0, 3'd0, 16'h0);
  endtask

  // Monitor: an entry leaves ID/EX when execute takes it or a flush kills it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && bus.ex_valid) begin
        if (bus.flush) begin
          if (sb.size() != 0) void'(sb.pop_front());
        end else if (bus.ex_ready) begin
          if (sb.size() == 0) begin
            chk("sb_nonempty", 32'h0, 32'h1);
          end else begin
            e = sb.pop_front();
            chk("ex_instr", {16'h0, bus.ex_instr}, {16'h0, e.instr});
            chk("ex_r1", {16'h0, bus.ex_r1}, {16'h0, e.r1});
            chk("ex_r2", {16'h0, bus.ex_r2}, {16'h0, e.r2});
            chk("ex_dst_en", {31'h0, bus.ex_dst_en}, {31'h0, e.de});
            chk("ex_dst_reg", {29'h0, bus.ex_dst_reg}, {29'h0, e.dr});
            chk("ex_load", {31'h0, bus.ex_load}, {31'h0, e.ld});
          end
        end
      end
    end
  end

  // Second instance: NREGS=6, ZERO_REG=1, no hazards, always ready.
  task automatic zstep(input logic iv, input logic [15:0] ins,
                       input logic we, input logic [2:0] wr, input logic [15:0] wd);
    @(negedge clk);
    bus_z.if_valid = iv; bus_z.if_instr = ins; bus_z.uses_rs = iv; bus_z.uses_rt = iv;
    bus_z.dst_en = 0; bus_z.dst_reg = 0; bus_z.dst_load = 0;
    bus_z.ex_ready = 1; bus_z.flush = 0;
    bus_z.wb_en = we; bus_z.wb_reg = wr; bus_z.wb_data = wd;
  endtask

  task automatic zread(input logic [2:0] rs, input logic [2:0] rt,
                       input logic [15:0] e1, input logic [15:0] e2);
    zstep(1, mk(rs, rt, 5'h0A), 0, 3'd0, 16'h0);
    zstep(0, 16'h0, 0, 3'd0, 16'h0);
    #1;
    chk("z_r1", {16'h0, bus_z.ex_r1}, {16'h0, e1});
    chk("z_r2", {16'h0, bus_z.ex_r2}, {16'h0, e2});
  endtask

  logic        p_iv, p_urs, p_urt, p_de, p_dl;
  logic [15:0] p_ins;
  logic [2:0]  p_dr;

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus_z.if_valid = 0; bus_z.if_instr = 0; bus_z.uses_rs = 0; bus_z.uses_rt = 0;
    bus_z.dst_en = 0; bus_z.dst_reg = 0; bus_z.dst_load = 0; bus_z.ex_ready = 1;
    bus_z.flush = 0; bus_z.wb_en = 0; bus_z.wb_reg = 0; bus_z.wb_data = 0;
    model_clear();
    last_acc = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_ex_valid", {31'h0, bus.ex_valid}, 32'h0);
    chk("rst_id_ready", {31'h0, bus.id_ready}, 32'h0);
    chk("rst_ex_instr", {16'h0, bus.ex_instr}, 32'h0);
    chk("rst_err", {31'h0, bus.err}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Bypass: write-back to R3 in the same cycle as an Rs=3 issue
    idle_step();
    step(1, mk(3'd3, 3'd0, 5'h01), 1, 0, 0, 3'd0, 0, 1, 0, 1, 3'd3, 16'hBEEF);
    idle_step();
    chk("bypass_r1", {16'h0, bus.ex_r1}, 32'hBEEF);
    step(1, mk(3'd0, 3'd3, 5'h02), 0, 1, 0, 3'd0, 0, 1, 0, 0, 3'd0, 16'h0);
    idle_step();
    chk("bypass_r2", {16'h0, bus.ex_r2}, 32'hBEEF);

    // Load-use: one bubble, then issue
    step(1, mk(3'd1, 3'd1, 5'h03), 0, 0, 1, 3'd2, 1, 1, 0, 0, 3'd0, 16'h0);
    step(1, mk(3'd2, 3'd0, 5'h04), 1, 0, 1, 3'd4, 0, 1, 0, 0, 3'd0, 16'h0);
    chk("lu_stall", {31'h0, bus.id_ready}, 32'h0);
    step(1, mk(3'd2, 3'd0, 5'h04), 1, 0, 1, 3'd4, 0, 1, 0, 0, 3'd0, 16'h0);
    chk("lu_bubble", {31'h0, bus.ex_valid}, 32'h0);
    chk("lu_issue", {31'h0, bus.id_ready}, 32'h1);
    step(1, mk(3'd1, 3'd1, 5'h05), 0, 0, 1, 3'd2, 1, 1, 0, 0, 3'd0, 16'h0);
    step(1, mk(3'd0, 3'd2, 5'h06), 1, 0, 0, 3'd0, 0, 1, 0, 0, 3'd0, 16'h0);
    chk("lu_rt_unused", {31'h0, bus.id_ready}, 32'h1);

    // Backpressure: entry held for three cycles, not refreshed by write-back to its sources
    idle_step();
    step(1, mk(3'd5, 3'd6, 5'h07), 1, 1, 1, 3'd5, 0, 1, 0, 1, 3'd5, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      step(1, mk(3'd1, 3'd2, 5'h08), 1, 1, 0, 3'd0, 0, 0, 0, 1, 3'd5, 16'h5555 + 16'(i));
      chk("bp_id_ready", {31'h0, bus.id_ready}, 32'h0);
      chk("bp_hold_r1", {16'h0, bus.ex_r1}, 32'h1234);
    end
    step(1, mk(3'd1, 3'd2, 5'h08), 1, 1, 0, 3'd0, 0, 1, 0, 0, 3'd0, 16'h0);
    chk("bp_release", {31'h0, bus.id_ready}, 32'h1);

    // Flush over a pending load-use stall
    step(1, mk(3'd1, 3'd1, 5'h09), 0, 0, 1, 3'd2, 1, 1, 0, 0, 3'd0, 16'h0);
    step(1, mk(3'd2, 3'd2, 5'h0A), 1, 1, 1, 3'd3, 0, 1, 1, 0, 3'd0, 16'h0);
    chk("fl_id_ready", {31'h0, bus.id_ready}, 32'h0);
    step(1, mk(3'd2, 3'd2, 5'h0A), 1, 1, 1, 3'd3, 0, 1, 0, 0, 3'd0, 16'h0);
    chk("fl_bubble", {31'h0, bus.ex_valid}, 32'h0);
    chk("fl_reissue", {31'h0, bus.id_ready}, 32'h1);

    // Randomized traffic; a refused instruction stays in IF/ID until taken
    for (int n = 0; n < 400; n++) begin
      if (!p_iv || last_acc || n == 0) begin
        p_iv  = ($urandom_range(0, 7) != 0);
        p_ins = 16'($urandom);
        p_urs = $urandom_range(0, 1) == 1;
        p_urt = $urandom_range(0, 1) == 1;
        p_de  = $urandom_range(0, 3) != 0;
        p_dr  = 3'($urandom_range(0, 7));
        p_dl  = $urandom_range(0, 2) == 0;
      end
      step(p_iv, p_ins, p_urs, p_urt, p_de, p_dr, p_dl,
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom));
    end

    // Reset mid-issue: held entry discarded at once, registers cleared
    step(1, mk(3'd4, 3'd5, 5'h0B), 0, 0, 1, 3'd1, 0, 1, 0, 1, 3'd4, 16'hA5A5);
    step(1, mk(3'd4, 3'd5, 5'h0C), 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0, 16'h0);
    @(negedge clk);
    idle_inputs();
    #3 rst = 1'b0;
    #1;
    chk("mr_ex_valid", {31'h0, bus.ex_valid}, 32'h0);
    chk("mr_ex_instr", {16'h0, bus.ex_instr}, 32'h0);
    chk("mr_ex_r1", {16'h0, bus.ex_r1}, 32'h0);
    chk("mr_ex_r2", {16'h0, bus.ex_r2}, 32'h0);
    chk("mr_ex_dst", {28'h0, bus.ex_dst_en, bus.ex_dst_reg}, 32'h0);
    chk("mr_ex_load", {31'h0, bus.ex_load}, 32'h0);
    chk("mr_id_ready", {31'h0, bus.id_ready}, 32'h0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step(1, mk(3'(i), 3'(i), 5'h0D), 1, 1, 0, 3'd0, 0, 1, 0, 0, 3'd0, 16'h0);
      idle_step();
      chk("post_rst_read", {bus.ex_r1, bus.ex_r2}, 32'h0);
    end

    // ZERO_REG=1 / NREGS=6 instance
    for (int i = 1; i < 6; i++) zstep(0, 16'h0, 1, 3'(i), 16'h1100 + 16'(i));
    zstep(0, 16'h0, 1, 3'd0, 16'h0005);
    zread(3'd0, 3'd1, 16'h0, 16'h1101);
    zstep(1, mk(3'd0, 3'd2, 5'h0E), 1, 3'd0, 16'h0005);
    zstep(0, 16'h0, 0, 3'd0, 16'h0);
    #1;
    chk("z_r0_bypass", {16'h0, bus_z.ex_r1}, 32'h0);
    zstep(0, 16'h0, 1, 3'd7, 16'hDEAD);
    zstep(0, 16'h0, 0, 3'd0, 16'h0);
    #1;
    chk("z_err_pulse", {31'h0, bus_z.err}, 32'h1);
    zstep(0, 16'h0, 0, 3'd0, 16'h0);
    #1;
    chk("z_err_clear", {31'h0, bus_z.err}, 32'h0);
    for (int i = 0; i < 6; i++)
      zread(3'(i), 3'(i), (i == 0) ? 16'h0 : 16'h1100 + 16'(i),
            (i == 0) ? 16'h0 : 16'h1100 + 16'(i));
    zread(3'd6, 3'd7, 16'h0, 16'h0);

    repeat (2) idle_step();
    chk("sb_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
